// File: rtl/cache_pkg.sv
// Shared cache-subsystem constants and enumerations for the
// memory-port arbiter and the caches around it.
package cache_pkg;

  localparam int WORD_SIZE   = 16;
  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2,
    D_WB   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the data-side memory port between I-cache line fills and D-cache
// fills/write-backs, sequencing each granted line as single-word accesses.
module mem_port_arbiter
  import cache_pkg::*;
#(
  parameter int WORD_SIZE  = cache_pkg::WORD_SIZE,
  parameter int LINE_WORDS = cache_pkg::LINE_WORDS,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_line_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_word_valid,
  output logic [IDX_W-1:0]     i_word_idx,
  output logic                 i_done,

  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_line_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_word_valid,
  output logic [IDX_W-1:0]     d_word_idx,
  output logic                 d_done,

  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready
);

  arb_state_t                  state;
  grant_t                      last_grant;
  logic [WORD_SIZE-IDX_W-1:0]  line_tag;
  logic [IDX_W-1:0]            word_cnt;
  logic [IDX_W-1:0]            d_idx_reg;
  logic                        active;
  logic                        last_word;
  logic                        grant_i;
  logic                        unused_offset;

  // Line offsets from the requesters are discarded; the burst supplies them.
  assign unused_offset = ^{i_line_addr[IDX_W-1:0], d_line_addr[IDX_W-1:0]};

  assign active    = (state != IDLE);
  assign last_word = (word_cnt == IDX_W'(LINE_WORDS - 1));
  // I wins when alone, or on a tie when D had the previous grant.
  assign grant_i   = i_req && (!d_req || (last_grant == GRANT_D));

  assign mem_read    = (state == I_FILL) || (state == D_FILL);
  assign mem_write   = (state == D_WB);
  assign mem_address = active ? {line_tag, word_cnt} : '0;
  assign mem_wdata   = mem_write ? d_wdata : '0;
  assign d_word_idx  = mem_write ? word_cnt : d_idx_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= GRANT_I;
      line_tag     <= '0;
      word_cnt     <= '0;
      d_idx_reg    <= '0;
      i_rdata      <= '0;
      i_word_valid <= 1'b0;
      i_word_idx   <= '0;
      i_done       <= 1'b0;
      d_rdata      <= '0;
      d_word_valid <= 1'b0;
      d_done       <= 1'b0;
    end else begin
      i_word_valid <= 1'b0;
      i_done       <= 1'b0;
      d_word_valid <= 1'b0;
      d_done       <= 1'b0;
      case (state)
        IDLE: begin
          word_cnt <= '0;
          if (grant_i) begin
            state    <= I_FILL;
            line_tag <= i_line_addr[WORD_SIZE-1:IDX_W];
          end else if (d_req) begin
            state    <= d_we ? D_WB : D_FILL;
            line_tag <= d_line_addr[WORD_SIZE-1:IDX_W];
          end
        end
        default: begin
          if (mem_ready) begin
            word_cnt <= last_word ? '0 : word_cnt + 1'b1;
            if (state == I_FILL) begin
              i_rdata      <= mem_rdata;
              i_word_valid <= 1'b1;
              i_word_idx   <= word_cnt;
              i_done       <= last_word;
            end else if (state == D_FILL) begin
              d_rdata      <= mem_rdata;
              d_word_valid <= 1'b1;
              d_idx_reg    <= word_cnt;
              d_done       <= last_word;
            end else begin
              d_done       <= last_word;
            end
            if (last_word) begin
              state      <= IDLE;
              last_grant <= (state == I_FILL) ? GRANT_I : GRANT_D;
            end
          end
        end
      endcase
    end
  end

endmodule
